me_access: RTL and testbench
============================

ME_ACCESS -- requirements
Module: me_access

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, the maximum number of BUSY cycles to wait for dm_ack before bus error.
REQ-002 SHALL have ports clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have ports me_w_enable / me_w_addr / me_w_data, inputs, 1/5/32, writeback request from the EX/ME register (me_w_data is the store data for stores).
REQ-005 SHALL have ports me_aluop / me_mem_addr, inputs, 8/32, operation and effective byte address from the EX/ME register.
REQ-006 SHALL have ports wb_w_enable / wb_w_addr / wb_w_data, outputs, 1/5/32, writeback result toward the ME/WB register.
REQ-007 SHALL have ports dm_req / dm_we / dm_be / dm_addr / dm_wdata, outputs, 1/1/4/32/32, registered data-memory request.
REQ-008 SHALL have ports dm_ack / dm_rdata, inputs, 1/32, memory completion strobe and word read data, valid in the dm_ack cycle.
REQ-009 SHALL have ports stall_req, misalign_exc, bus_err, outputs, 1 each: pipeline hold request to the stall controller (drives stall[4:0]), one-cycle exception pulses.

Function
REQ-010 SHALL treat EX_LB/LH/LW/LBU/LHU_OP as loads, EX_SB/SH/SW_OP as stores; every other aluop is non-memory.
REQ-011 Non-memory op in IDLE SHALL pass me_w_* to wb_w_* combinationally, zero latency, stall_req=0.
REQ-012 FSM states SHALL be IDLE, BUSY, DONE.
REQ-013 IDLE + aligned memory op: stall_req=1, wb_w_enable=0 combinationally; next edge registers the request, dm_req=1, state BUSY.
REQ-014 Misalignment SHALL be LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; then no request, misalign_exc=1 for that cycle, wb_w_enable=0, stall_req=0, stay IDLE.
REQ-015 dm_addr SHALL be {me_mem_addr[31:2],2'b00}; dm_we=1 for stores only.
REQ-016 Store lanes: SB be=1<<addr[1:0], wdata=byte replicated x4; SH be=addr[1]?1100:0011, wdata=half replicated x2; SW be=1111, wdata=data. Loads: be per same rule, wdata=0.
REQ-017 BUSY: dm_req and all dm_* held stable, stall_req=1, wait counter increments each cycle.
REQ-018 BUSY + dm_ack: load result captured (lane by addr[1:0], LB/LH sign-extend, LBU/LHU zero-extend), dm_req deasserted, state DONE.
REQ-019 BUSY with counter=MAX_WAIT and no dm_ack: bus_err pulses for that cycle, dm_req deasserted, DONE with write suppressed.
REQ-020 DONE (exactly one cycle): stall_req=0; loads present wb_w_enable=me_w_enable, wb_w_addr, captured data; stores present wb_w_enable=0; next state IDLE.
REQ-021 dm_ack outside BUSY SHALL be ignored.
REQ-022 Counter SHALL clear on entry to BUSY and SHALL not wrap (8-bit wide for default).

Reset
REQ-023 rst=0 at an edge SHALL set state IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, counter=0, captured data=0, including mid-BUSY (request abandoned).
REQ-024 While rst=0, wb_w_enable, wb_w_addr, wb_w_data, stall_req, misalign_exc, bus_err SHALL be 0.

Structure
REQ-025 aluop codes and FSM state encodings SHALL live in the shared defines (ALUInstDef.v / Defines.v); RegBus/RegAddrBus widths reused.
REQ-026 Lane logic (store replicate/byte-enable, load extract/extend) SHALL be one combinational sub-module me_lane_align.

Verification
REQ-027 SW addr 0x100 data 0xDEADBEEF, ack on 2nd BUSY cycle -> dm_be=1111, dm_wdata=0xDEADBEEF, stall_req high 3 cycles, DONE wb_w_enable=0.
REQ-028 LB addr 0x103, rdata 0x80FF0000 -> wb_w_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-029 LW addr 0x102 -> misalign_exc one cycle, dm_req never asserted, stall_req=0.
REQ-030 LW with dm_ack never asserted, MAX_WAIT=4 -> bus_err after 5th BUSY cycle, DONE with wb_w_enable=0, back to IDLE.
REQ-031 rst low during BUSY -> dm_req=0 next edge, IDLE; following ADD op passes through same cycle.
REQ-032 Back-to-back SB 0x201 (0xAB) then LW 0x200 -> dm_be=0010, dm_wdata=0xABABABAB, then LW issued after DONE.

Source files
------------

// File: rtl/me_access_pkg.sv
// Shared definitions for the memory-access stage: aluop codes, FSM states, bus widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package me_access_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;

    localparam logic [ALUOP_W-1:0] EX_NOP_OP = 8'h00;
    localparam logic [ALUOP_W-1:0] EX_ADD_OP = 8'h20;
    localparam logic [ALUOP_W-1:0] EX_LB_OP  = 8'he0;
    localparam logic [ALUOP_W-1:0] EX_LH_OP  = 8'he1;
    localparam logic [ALUOP_W-1:0] EX_LW_OP  = 8'he3;
    localparam logic [ALUOP_W-1:0] EX_LBU_OP = 8'he4;
    localparam logic [ALUOP_W-1:0] EX_LHU_OP = 8'he5;
    localparam logic [ALUOP_W-1:0] EX_SB_OP  = 8'he8;
    localparam logic [ALUOP_W-1:0] EX_SH_OP  = 8'he9;
    localparam logic [ALUOP_W-1:0] EX_SW_OP  = 8'heb;

    typedef enum logic [1:0] {
        ME_IDLE = 2'd0,
        ME_BUSY = 2'd1,
        ME_DONE = 2'd2
    } me_state_t;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return (op == EX_LB_OP) || (op == EX_LH_OP) || (op == EX_LW_OP) ||
               (op == EX_LBU_OP) || (op == EX_LHU_OP);
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] a);
        case (op)
            EX_LH_OP, EX_LHU_OP, EX_SH_OP: return a[0];
            EX_LW_OP, EX_SW_OP:            return (a != 2'b00);
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/me_access_lane_align.sv
// Byte-lane steering: store byte-enable/replication and load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: st_* store/request side (op, addr[1:0], data -> be, wdata);
//        ld_* load side (op, addr[1:0], word rdata -> extended result).
module me_lane_align
    import me_access_pkg::*;
(
    input  logic [ALUOP_W-1:0]   st_op,
    input  logic [1:0]           st_lane,
    input  logic [REG_BUS_W-1:0] st_data,
    output logic [3:0]           st_be,
    output logic [REG_BUS_W-1:0] st_wdata,
    input  logic [ALUOP_W-1:0]   ld_op,
    input  logic [1:0]           ld_lane,
    input  logic [REG_BUS_W-1:0] ld_rdata,
    output logic [REG_BUS_W-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Loads use the same byte-enables as the equivalent store but never drive data.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = '0;
        case (st_op)
            EX_SB_OP: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            EX_LB_OP, EX_LBU_OP: st_be = 4'b0001 << st_lane;
            EX_SH_OP: begin
                st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            EX_LH_OP, EX_LHU_OP: st_be = st_lane[1] ? 4'b1100 : 4'b0011;
            EX_SW_OP: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
            EX_LW_OP: st_be = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[7:0];
        case (ld_lane)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            2'd3: ld_byte = ld_rdata[31:24];
            default: ;
        endcase
        ld_half = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

        ld_data = '0;
        case (ld_op)
            EX_LB_OP:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            EX_LBU_OP: ld_data = {24'd0, ld_byte};
            EX_LH_OP:  ld_data = {{16{ld_half[15]}}, ld_half};
            EX_LHU_OP: ld_data = {16'd0, ld_half};
            EX_LW_OP:  ld_data = ld_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/me_access.sv
// Memory-access pipeline stage: issues one data-memory request per load/store, returns load data.
// Latency: non-memory ops 0 cycles; memory ops issue + ack wait + 1 DONE cycle.
// Backpressure: holds the pipeline via stall_req while a request is pending; times out after MAX_WAIT.
// Ports: me_* from EX/ME register, wb_* toward ME/WB register, dm_* data-memory handshake,
//        stall_req to the stall controller, misalign_exc / bus_err one-cycle exception pulses.
module me_access
    import me_access_pkg::*;
#(
    parameter int MAX_WAIT = 255
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  me_w_enable,
    input  logic [REG_ADDR_W-1:0] me_w_addr,
    input  logic [REG_BUS_W-1:0]  me_w_data,
    input  logic [ALUOP_W-1:0]    me_aluop,
    input  logic [REG_BUS_W-1:0]  me_mem_addr,
    output logic                  wb_w_enable,
    output logic [REG_ADDR_W-1:0] wb_w_addr,
    output logic [REG_BUS_W-1:0]  wb_w_data,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [3:0]            dm_be,
    output logic [REG_BUS_W-1:0]  dm_addr,
    output logic [REG_BUS_W-1:0]  dm_wdata,
    input  logic                  dm_ack,
    input  logic [REG_BUS_W-1:0]  dm_rdata,
    output logic                  stall_req,
    output logic                  misalign_exc,
    output logic                  bus_err
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    me_state_t            state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [ALUOP_W-1:0]   req_op;
    logic [1:0]           req_lane;
    logic                 timed_out;
    logic [REG_BUS_W-1:0] cap_data;

    logic                 mem_op;
    logic                 misaligned;
    logic [3:0]           lane_be;
    logic [REG_BUS_W-1:0] lane_wdata;
    logic [REG_BUS_W-1:0] lane_ld_data;

    assign mem_op     = is_load(me_aluop) || is_store(me_aluop);
    assign misaligned = is_misaligned(me_aluop, me_mem_addr[1:0]);

    // Store side is driven from the live EX/ME op; load side from the op latched at issue.
    me_lane_align u_lane (
        .st_op    (me_aluop),
        .st_lane  (me_mem_addr[1:0]),
        .st_data  (me_w_data),
        .st_be    (lane_be),
        .st_wdata (lane_wdata),
        .ld_op    (req_op),
        .ld_lane  (req_lane),
        .ld_rdata (dm_rdata),
        .ld_data  (lane_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ME_IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= 4'b0000;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            wait_cnt  <= '0;
            req_op    <= EX_NOP_OP;
            req_lane  <= 2'b00;
            timed_out <= 1'b0;
            cap_data  <= '0;
        end else begin
            case (state)
                ME_IDLE: begin
                    if (mem_op && !misaligned) begin
                        dm_req    <= 1'b1;
                        dm_we     <= is_store(me_aluop);
                        dm_be     <= lane_be;
                        dm_addr   <= {me_mem_addr[31:2], 2'b00};
                        dm_wdata  <= lane_wdata;
                        req_op    <= me_aluop;
                        req_lane  <= me_mem_addr[1:0];
                        wait_cnt  <= '0;
                        timed_out <= 1'b0;
                        state     <= ME_BUSY;
                    end
                end
                ME_BUSY: begin
                    if (dm_ack) begin
                        cap_data <= lane_ld_data;
                        dm_req   <= 1'b0;
                        state    <= ME_DONE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        // Counter stops here, so it can never wrap.
                        dm_req    <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= ME_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ME_DONE: state <= ME_IDLE;
                default: state <= ME_IDLE;
            endcase
        end
    end

    always_comb begin
        wb_w_enable  = 1'b0;
        wb_w_addr    = '0;
        wb_w_data    = '0;
        stall_req    = 1'b0;
        misalign_exc = 1'b0;
        bus_err      = 1'b0;
        if (rst) begin
            case (state)
                ME_IDLE: begin
                    if (!mem_op) begin
                        wb_w_enable = me_w_enable;
                        wb_w_addr   = me_w_addr;
                        wb_w_data   = me_w_data;
                    end else if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
                ME_BUSY: begin
                    stall_req = 1'b1;
                    bus_err   = !dm_ack && (wait_cnt == WAIT_LIMIT);
                end
                ME_DONE: begin
                    // Stores and timed-out loads retire without a register write.
                    if (is_load(req_op) && !timed_out) begin
                        wb_w_enable = me_w_enable;
                        wb_w_addr   = me_w_addr;
                        wb_w_data   = cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_me_access.sv
// Self-checking bench for me_access: per-cycle reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: a simple memory responder acks after a programmable number of request cycles.
module tb_me_access;
    import me_access_pkg::*;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        me_w_enable = 1'b0;
    logic [4:0]  me_w_addr = '0;
    logic [31:0] me_w_data = '0;
    logic [7:0]  me_aluop = EX_NOP_OP;
    logic [31:0] me_mem_addr = '0;
    logic        wb_w_enable;
    logic [4:0]  wb_w_addr;
    logic [31:0] wb_w_data;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        stall_req, misalign_exc, bus_err;

    always #5 clk = ~clk;

    me_access #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .me_w_enable(me_w_enable), .me_w_addr(me_w_addr), .me_w_data(me_w_data),
        .me_aluop(me_aluop), .me_mem_addr(me_mem_addr),
        .wb_w_enable(wb_w_enable), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_req(stall_req), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic bit f_load(input logic [7:0] op);
        return op inside {EX_LB_OP, EX_LH_OP, EX_LW_OP, EX_LBU_OP, EX_LHU_OP};
    endfunction
    function automatic bit f_store(input logic [7:0] op);
        return op inside {EX_SB_OP, EX_SH_OP, EX_SW_OP};
    endfunction
    function automatic int f_size(input logic [7:0] op);
        if (op inside {EX_LB_OP, EX_LBU_OP, EX_SB_OP}) return 1;
        if (op inside {EX_LH_OP, EX_LHU_OP, EX_SH_OP}) return 2;
        return 4;
    endfunction
    function automatic bit f_mis(input logic [7:0] op, input logic [31:0] a);
        if (!(f_load(op) || f_store(op))) return 0;
        return (a % f_size(op)) != 0;
    endfunction
    function automatic logic [3:0] f_be(input logic [7:0] op, input logic [31:0] a);
        int sz, base;
        sz = f_size(op);
        base = (a % 4) / sz * sz;
        return 4'(((1 << sz) - 1) << base);
    endfunction
    function automatic logic [31:0] f_wd(input logic [7:0] op, input logic [31:0] d);
        if (op == EX_SB_OP) return (d & 32'hFF) * 32'h01010101;
        if (op == EX_SH_OP) return (d & 32'hFFFF) * 32'h00010001;
        if (op == EX_SW_OP) return d;
        return 32'h0;
    endfunction
    function automatic logic [31:0] f_ext(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
        int sz;
        longint v;
        sz = f_size(op);
        if (sz == 4) return rd;
        v = (rd >> (8 * ((a % 4) / sz * sz))) & ((64'd1 << (8 * sz)) - 1);
        if ((op == EX_LB_OP || op == EX_LH_OP) && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    // Model state: 0 = no transaction, 1 = request outstanding, 2 = retiring.
    int          m_phase = 0;
    int          m_wait = 0;
    bit          m_err = 0;
    logic [31:0] m_cap = '0;
    logic [7:0]  m_op = EX_NOP_OP;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0;
            m_wait  = 0;
            m_cap   = '0;
        end else begin
            case (m_phase)
                0: if ((f_load(me_aluop) || f_store(me_aluop)) && !f_mis(me_aluop, me_mem_addr)) begin
                    m_phase = 1; m_wait = 0; m_err = 0;
                    m_op = me_aluop; m_addr = me_mem_addr; m_data = me_w_data;
                end
                1: if (dm_ack) begin
                    if (f_load(m_op)) m_cap = f_ext(m_op, m_addr, dm_rdata);
                    m_phase = 2;
                end else if (m_wait == MW) begin
                    m_err = 1; m_phase = 2;
                end else begin
                    m_wait++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic        e_wen, e_stall, e_mis, e_berr;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdat;
        bit          memop;
        if (chk_en) begin
            e_wen = 0; e_waddr = 0; e_wdat = 0; e_stall = 0; e_mis = 0; e_berr = 0;
            memop = f_load(me_aluop) || f_store(me_aluop);
            if (rst) begin
                if (m_phase == 0) begin
                    if (!memop) begin
                        e_wen = me_w_enable; e_waddr = me_w_addr; e_wdat = me_w_data;
                    end else if (f_mis(me_aluop, me_mem_addr)) e_mis = 1;
                    else e_stall = 1;
                end else if (m_phase == 1) begin
                    e_stall = 1;
                    e_berr  = (m_wait == MW) && !dm_ack;
                end else if (f_load(m_op) && !m_err) begin
                    e_wen = me_w_enable; e_waddr = me_w_addr; e_wdat = m_cap;
                end
            end
            chk("wb_w_enable", 32'(wb_w_enable), 32'(e_wen));
            chk("wb_w_addr", 32'(wb_w_addr), 32'(e_waddr));
            chk("wb_w_data", wb_w_data, e_wdat);
            chk("stall_req", 32'(stall_req), 32'(e_stall));
            chk("misalign_exc", 32'(misalign_exc), 32'(e_mis));
            chk("bus_err", 32'(bus_err), 32'(e_berr));
            chk("dm_req", 32'(dm_req), 32'(m_phase == 1));
            if (m_phase == 1) begin
                chk("dm_we", 32'(dm_we), 32'(f_store(m_op)));
                chk("dm_be", 32'(dm_be), 32'(f_be(m_op, m_addr)));
                chk("dm_addr", dm_addr, m_addr & ~32'h3);
                chk("dm_wdata", dm_wdata, f_wd(m_op, m_data));
            end
        end
    end

    // ---------------- memory responder ----------------
    int          ack_after = 0;
    int          busy_n = 0;
    bit          ack_force = 0;
    logic [31:0] rd_val = '0;

    always @(posedge clk) begin
        #2;
        if (rst && dm_req && ack_after > 0) begin
            busy_n++;
            dm_ack   = (busy_n == ack_after);
            dm_rdata = rd_val;
        end else begin
            busy_n = 0;
            dm_ack = ack_force;
        end
    end

    // ---------------- directed stimulus ----------------
    int          s_n, e_n, mi_n;
    bit          rq;
    logic [3:0]  o_be;
    logic [31:0] o_wd, o_wdat;
    logic        o_wen;

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int ack_a, input logic [31:0] rd);
        bit done;
        done = 0; s_n = 0; e_n = 0; mi_n = 0; rq = 0; o_be = 'x; o_wd = 'x; o_wen = 'x; o_wdat = 'x;
        @(posedge clk); #2;
        me_aluop = op; me_mem_addr = addr; me_w_data = data; me_w_enable = 1'b1; me_w_addr = 5'd9;
        ack_after = ack_a; rd_val = rd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall_req) s_n++;
            if (bus_err) e_n++;
            if (misalign_exc) mi_n++;
            if (dm_req) begin rq = 1; o_be = dm_be; o_wd = dm_wdata; end
            if (!stall_req) begin
                done = 1; o_wen = wb_w_enable; o_wdat = wb_w_data;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL op_timeout: stall_req still high after 20 cycles, required low");
        end
    endtask

    initial begin
        // Reset with a live ADD on the inputs: outputs must stay quiet.
        me_aluop = EX_ADD_OP; me_w_enable = 1'b1; me_w_addr = 5'd3; me_w_data = 32'h55;
        repeat (2) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_dm_req", 32'(dm_req), 32'h0);
        chk("rst_dm_be", 32'(dm_be), 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_wb_w_enable", 32'(wb_w_enable), 32'h0);
        @(posedge clk); #2; rst = 1'b1;

        run_op(EX_ADD_OP, 32'h0, 32'h12345678, 0, 32'h0);
        chk("add_wen", 32'(o_wen), 32'h1);
        chk("add_data", o_wdat, 32'h12345678);
        chk("add_stall", 32'(s_n), 32'd0);

        run_op(EX_SW_OP, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        chk("sw_be", 32'(o_be), 32'hF);
        chk("sw_wdata", o_wd, 32'hDEADBEEF);
        chk("sw_stall_cycles", 32'(s_n), 32'd3);
        chk("sw_done_wen", 32'(o_wen), 32'h0);

        run_op(EX_LB_OP, 32'h103, 32'h0, 1, 32'h80FF0000);
        chk("lb_data", o_wdat, 32'hFFFFFF80);
        chk("lb_wen", 32'(o_wen), 32'h1);
        run_op(EX_LBU_OP, 32'h103, 32'h0, 1, 32'h80FF0000);
        chk("lbu_data", o_wdat, 32'h00000080);
        run_op(EX_LHU_OP, 32'h102, 32'h0, 1, 32'h80FF0000);
        chk("lhu_data", o_wdat, 32'h000080FF);
        run_op(EX_LH_OP, 32'h100, 32'h0, 2, 32'h1234F00D);
        chk("lh_data", o_wdat, 32'hFFFFF00D);

        run_op(EX_LW_OP, 32'h102, 32'h0, 1, 32'h0);
        chk("lw_mis_exc", 32'(mi_n), 32'd1);
        chk("lw_mis_req", 32'(rq), 32'd0);
        chk("lw_mis_stall", 32'(s_n), 32'd0);
        run_op(EX_LH_OP, 32'h101, 32'h0, 1, 32'h0);
        chk("lh_mis_exc", 32'(mi_n), 32'd1);

        run_op(EX_SH_OP, 32'h102, 32'h00001234, 3, 32'h0);
        chk("sh_be", 32'(o_be), 32'hC);
        chk("sh_wdata", o_wd, 32'h12341234);

        run_op(EX_LW_OP, 32'h104, 32'h0, 0, 32'h0);
        chk("to_bus_err", 32'(e_n), 32'd1);
        chk("to_stall_cycles", 32'(s_n), 32'd6);
        chk("to_wen", 32'(o_wen), 32'h0);

        run_op(EX_SB_OP, 32'h201, 32'h000000AB, 1, 32'h0);
        chk("sb_be", 32'(o_be), 32'h2);
        chk("sb_wdata", o_wd, 32'hABABABAB);
        run_op(EX_LW_OP, 32'h200, 32'h0, 1, 32'h11223344);
        chk("b2b_lw_be", 32'(o_be), 32'hF);
        chk("b2b_lw_data", o_wdat, 32'h11223344);

        // Stray acks while idle must not start or alter anything.
        ack_force = 1;
        run_op(EX_ADD_OP, 32'h0, 32'h0000BEEF, 0, 32'h0);
        run_op(EX_ADD_OP, 32'h0, 32'h0000CAFE, 0, 32'h0);
        chk("stray_ack_req", 32'(rq), 32'd0);
        chk("stray_ack_data", o_wdat, 32'h0000CAFE);
        ack_force = 0;

        // Reset while a request is outstanding.
        @(posedge clk); #2;
        me_aluop = EX_LW_OP; me_mem_addr = 32'h300; ack_after = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rb_dm_req_busy", 32'(dm_req), 32'h1);
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("rb_stall_in_rst", 32'(stall_req), 32'h0);
        @(posedge clk); #2;
        rst = 1'b1; me_aluop = EX_ADD_OP; me_w_data = 32'hCAFEF00D; me_w_addr = 5'd4;
        @(negedge clk);
        chk("rb_dm_req_after", 32'(dm_req), 32'h0);
        chk("rb_add_wen", 32'(wb_w_enable), 32'h1);
        chk("rb_add_data", wb_w_data, 32'hCAFEF00D);

        @(posedge clk); #2; me_aluop = EX_NOP_OP;
        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
